// File: rtl/mips_pkg.sv
// Shared constants and control-field types for the 5-stage MIPS pipeline latches.
package mips_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  typedef logic [1:0] ctl_wb_t;
  typedef logic [2:0] ctl_m_t;
endpackage

// File: rtl/ex_mem_latch_if.sv
// EX-to-MEM bundle: EX-stage results and hazard controls in, registered MEM-stage view out.
interface ex_mem_latch_if
  import mips_pkg::*;
#(
  parameter int DW = mips_pkg::DATA_W,
  parameter int RW = mips_pkg::REG_ADDR_W
);
  logic          stall;
  logic          flush;
  ctl_wb_t       ctlwb_in;
  ctl_m_t        ctlm_in;
  logic [DW-1:0] add_result_in;
  logic          alu_zero_in;
  logic [DW-1:0] alu_result_in;
  logic [DW-1:0] rdata2_in;
  logic [RW-1:0] dest_reg_in;
  logic          valid_in;

  ctl_wb_t       ctlwb_out;
  logic          branch_out;
  logic          memread_out;
  logic          memwrite_out;
  logic [DW-1:0] add_result_out;
  logic          alu_zero_out;
  logic [DW-1:0] alu_result_out;
  logic [DW-1:0] rdata2_out;
  logic [RW-1:0] dest_reg_out;
  logic          valid_out;
  logic          pcsrc_out;

  modport master (
    output stall, flush, ctlwb_in, ctlm_in, add_result_in, alu_zero_in,
           alu_result_in, rdata2_in, dest_reg_in, valid_in,
    input  ctlwb_out, branch_out, memread_out, memwrite_out, add_result_out,
           alu_zero_out, alu_result_out, rdata2_out, dest_reg_out, valid_out,
           pcsrc_out
  );

  modport slave (
    input  stall, flush, ctlwb_in, ctlm_in, add_result_in, alu_zero_in,
           alu_result_in, rdata2_in, dest_reg_in, valid_in,
    output ctlwb_out, branch_out, memread_out, memwrite_out, add_result_out,
           alu_zero_out, alu_result_out, rdata2_out, dest_reg_out, valid_out,
           pcsrc_out
  );
endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: sync reset, sync clear, load enable. Clear beats load.
module pipe_field_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst || clear) q <= '0;
    else if (load)    q <= d;
  end
endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush and a registered-only branch-taken decision.
module ex_mem_latch #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_latch_if.slave bus
);
  import mips_pkg::ctl_m_t;
  import mips_pkg::ctl_wb_t;
  import mips_pkg::M_BRANCH;
  import mips_pkg::M_MEMREAD;
  import mips_pkg::M_MEMWRITE;

  localparam int CW = 6;
  localparam int DW = 3 * DATA_W + 1 + REG_ADDR_W;

  logic          load;
  logic [CW-1:0] ctl_d;
  logic [CW-1:0] ctl_q;
  logic [DW-1:0] dat_d;
  logic [DW-1:0] dat_q;
  ctl_wb_t       wb_q;
  ctl_m_t        m_q;
  logic          valid_q;

  // Flush must still take effect under stall, so it forces the load.
  assign load  = ~bus.stall | bus.flush;
  // An invalid slot carries no side effects: its controls are squashed at capture.
  assign ctl_d = bus.valid_in ? {bus.ctlwb_in, bus.ctlm_in, 1'b1} : '0;
  assign dat_d = {bus.add_result_in, bus.alu_zero_in, bus.alu_result_in,
                  bus.rdata2_in, bus.dest_reg_in};

  pipe_field_reg #(.W(CW)) u_ctl (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (bus.flush),
    .d     (ctl_d),
    .q     (ctl_q)
  );

  pipe_field_reg #(.W(DW)) u_dat (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (1'b0),
    .d     (dat_d),
    .q     (dat_q)
  );

  assign {wb_q, m_q, valid_q} = ctl_q;

  assign bus.ctlwb_out    = wb_q;
  assign bus.branch_out   = m_q[M_BRANCH];
  assign bus.memread_out  = m_q[M_MEMREAD];
  assign bus.memwrite_out = m_q[M_MEMWRITE];
  assign bus.valid_out    = valid_q;

  assign {bus.add_result_out, bus.alu_zero_out, bus.alu_result_out,
          bus.rdata2_out, bus.dest_reg_out} = dat_q;

  assign bus.pcsrc_out = m_q[M_BRANCH] & bus.alu_zero_out & valid_q;
endmodule

// File: tb/tb_ex_mem_latch.sv
// Bench for ex_mem_latch: directed vector table, then random traffic against a field-level model.
module tb_ex_mem_latch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  ex_mem_latch_if bus ();

  ex_mem_latch u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        valid;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dest;
  } mdl_t;

  mdl_t mdl;

  typedef struct {
    logic        rst, stall, flush;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dest;
    logic        valid;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic        e_valid;
    logic        e_pcsrc;
    logic [31:0] e_alu;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic r, logic s, logic f, logic [1:0] wb, logic [2:0] m,
                              logic [31:0] add, logic z, logic [31:0] alu, logic [31:0] rd2,
                              logic [4:0] dest, logic v, logic [1:0] e_wb, logic [2:0] e_m,
                              logic e_v, logic e_pc, logic [31:0] e_alu);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.wb = wb; t.m = m; t.add = add; t.zero = z;
    t.alu = alu; t.rd2 = rd2; t.dest = dest; t.valid = v;
    t.e_wb = e_wb; t.e_m = e_m; t.e_valid = e_v; t.e_pcsrc = e_pc; t.e_alu = e_alu;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic s, logic f, logic [1:0] wb, logic [2:0] m,
                       logic [31:0] add, logic z, logic [31:0] alu, logic [31:0] rd2,
                       logic [4:0] dest, logic v);
    rst = r; bus.stall = s; bus.flush = f; bus.ctlwb_in = wb; bus.ctlm_in = m;
    bus.add_result_in = add; bus.alu_zero_in = z; bus.alu_result_in = alu;
    bus.rdata2_in = rd2; bus.dest_reg_in = dest; bus.valid_in = v;
  endtask

  // Reference: reset clears all; flush bubbles controls but takes data;
  // stall holds; a normal load takes data and takes controls only for a valid slot.
  task automatic model_edge();
    if (rst) begin
      mdl = '{default: '0};
    end else if (bus.flush || !bus.stall) begin
      mdl.add  = bus.add_result_in;
      mdl.zero = bus.alu_zero_in;
      mdl.alu  = bus.alu_result_in;
      mdl.rd2  = bus.rdata2_in;
      mdl.dest = bus.dest_reg_in;
      if (bus.flush || !bus.valid_in) begin
        mdl.wb = 2'b00; mdl.m = 3'b000; mdl.valid = 1'b0;
      end else begin
        mdl.wb = bus.ctlwb_in; mdl.m = bus.ctlm_in; mdl.valid = 1'b1;
      end
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".ctlwb"},    64'(bus.ctlwb_out),      64'(mdl.wb));
    chk({tag, ".branch"},   64'(bus.branch_out),     64'(mdl.m[2]));
    chk({tag, ".memread"},  64'(bus.memread_out),    64'(mdl.m[1]));
    chk({tag, ".memwrite"}, 64'(bus.memwrite_out),   64'(mdl.m[0]));
    chk({tag, ".valid"},    64'(bus.valid_out),      64'(mdl.valid));
    chk({tag, ".add"},      64'(bus.add_result_out), 64'(mdl.add));
    chk({tag, ".zero"},     64'(bus.alu_zero_out),   64'(mdl.zero));
    chk({tag, ".alu"},      64'(bus.alu_result_out), 64'(mdl.alu));
    chk({tag, ".rdata2"},   64'(bus.rdata2_out),     64'(mdl.rd2));
    chk({tag, ".dest"},     64'(bus.dest_reg_out),   64'(mdl.dest));
    chk({tag, ".pcsrc"},    64'(bus.pcsrc_out),      64'(mdl.m[2] & mdl.zero & mdl.valid));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    mdl = '{default: '0};
    drive(1'b1, 1'b1, 1'b1, 2'b11, 3'b111, '1, 1'b1, '1, '1, '1, 1'b1);

    //            rst  stl  fls  wb     m       add           z     alu           rd2           dest  v     e_wb   e_m     e_v   e_pc  e_alu
    vecs[0]  = mk(1'b1,1'b1,1'b1,2'b11,3'b111,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,32'hFFFF_FFFF,5'h1F,1'b1, 2'b00,3'b000,1'b0,1'b0,32'h0);
    vecs[1]  = mk(1'b1,1'b1,1'b1,2'b11,3'b111,32'hFFFF_FFFF,1'b1,32'hFFFF_FFFF,32'hFFFF_FFFF,5'h1F,1'b1, 2'b00,3'b000,1'b0,1'b0,32'h0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,2'b10,3'b100,32'h0000_0040,1'b1,32'h0,         32'hDEAD_BEEF,5'd9, 1'b1, 2'b10,3'b100,1'b1,1'b1,32'h0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,2'b10,3'b100,32'h0000_0040,1'b0,32'h0,         32'hDEAD_BEEF,5'd9, 1'b1, 2'b10,3'b100,1'b1,1'b0,32'h0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,2'b10,3'b000,32'h0,        1'b0,32'h1234_5678,32'h0,        5'd3, 1'b1, 2'b10,3'b000,1'b1,1'b0,32'h1234_5678);
    vecs[5]  = mk(1'b0,1'b1,1'b0,2'b01,3'b111,32'h0,        1'b1,32'hFFFF_FFFF,32'h0,        5'd4, 1'b1, 2'b10,3'b000,1'b1,1'b0,32'h1234_5678);
    vecs[6]  = mk(1'b0,1'b1,1'b0,2'b01,3'b111,32'h0,        1'b1,32'hFFFF_FFFF,32'h0,        5'd4, 1'b1, 2'b10,3'b000,1'b1,1'b0,32'h1234_5678);
    vecs[7]  = mk(1'b0,1'b1,1'b0,2'b01,3'b111,32'h0,        1'b1,32'hFFFF_FFFF,32'h0,        5'd4, 1'b1, 2'b10,3'b000,1'b1,1'b0,32'h1234_5678);
    vecs[8]  = mk(1'b0,1'b0,1'b0,2'b01,3'b010,32'h0,        1'b1,32'hFFFF_FFFF,32'h0,        5'd4, 1'b1, 2'b01,3'b010,1'b1,1'b0,32'hFFFF_FFFF);
    vecs[9]  = mk(1'b0,1'b0,1'b1,2'b11,3'b001,32'h0,        1'b1,32'h0000_0100,32'hCAFE_0001,5'd5, 1'b1, 2'b00,3'b000,1'b0,1'b0,32'h0000_0100);
    vecs[10] = mk(1'b0,1'b1,1'b1,2'b11,3'b001,32'h0,        1'b1,32'h0000_0200,32'hCAFE_0002,5'd6, 1'b1, 2'b00,3'b000,1'b0,1'b0,32'h0000_0200);
    vecs[11] = mk(1'b0,1'b0,1'b0,2'b11,3'b111,32'h0000_0080,1'b1,32'h0000_0300,32'h0,        5'd7, 1'b0, 2'b00,3'b000,1'b0,1'b0,32'h0000_0300);
    vecs[12] = mk(1'b0,1'b0,1'b0,2'b00,3'b100,32'h0000_0044,1'b1,32'h0,        32'h0,        5'd0, 1'b1, 2'b00,3'b100,1'b1,1'b1,32'h0);
    vecs[13] = mk(1'b0,1'b1,1'b0,2'b11,3'b011,32'h0,        1'b0,32'h0000_0999,32'h0,        5'd8, 1'b1, 2'b00,3'b100,1'b1,1'b1,32'h0);
    vecs[14] = mk(1'b1,1'b1,1'b0,2'b11,3'b011,32'h0,        1'b0,32'h0000_0999,32'h0,        5'd8, 1'b1, 2'b00,3'b000,1'b0,1'b0,32'h0);
    vecs[15] = mk(1'b0,1'b0,1'b0,2'b01,3'b010,32'h0,        1'b0,32'h0000_0055,32'h0,        5'd8, 1'b1, 2'b01,3'b010,1'b1,1'b0,32'h0000_0055);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].wb, vecs[i].m, vecs[i].add,
            vecs[i].zero, vecs[i].alu, vecs[i].rd2, vecs[i].dest, vecs[i].valid);
      clock_edge();
      chk($sformatf("vec%0d.ctlwb", i), 64'(bus.ctlwb_out), 64'(vecs[i].e_wb));
      chk($sformatf("vec%0d.ctlm", i),
          64'({bus.branch_out, bus.memread_out, bus.memwrite_out}), 64'(vecs[i].e_m));
      chk($sformatf("vec%0d.valid", i), 64'(bus.valid_out), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.pcsrc", i), 64'(bus.pcsrc_out), 64'(vecs[i].e_pcsrc));
      chk($sformatf("vec%0d.alu", i), 64'(bus.alu_result_out), 64'(vecs[i].e_alu));
      check_model($sformatf("vec%0d", i));
    end

    // Branch held across a stall keeps pcsrc for every stalled cycle, then drops on release.
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 32'h0000_0010, 1'b1, 32'h0, 32'h0, 5'd0, 1'b1);
    clock_edge();
    chk("hold.pcsrc0", 64'(bus.pcsrc_out), 64'd1);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      clock_edge();
      chk($sformatf("hold.pcsrc_stall%0d", k), 64'(bus.pcsrc_out), 64'd1);
      chk($sformatf("hold.add%0d", k), 64'(bus.add_result_out), 64'h10);
    end
    bus.stall = 1'b0;
    clock_edge();
    chk("hold.pcsrc_release", 64'(bus.pcsrc_out), 64'd0);
    check_model("hold");

    for (int n = 0; n < 500; n++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), 2'($urandom), 3'($urandom), $urandom,
            1'($urandom), $urandom, $urandom, 5'($urandom), ($urandom_range(0, 3) != 0));
      clock_edge();
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
